// File: rtl/ipgu_window_addr_gen_pkg.sv
// ipgu_pkg: shared types and constants for the IPGU sliding-window address
// generator. It holds the FSM state type, the default window geometry and
// the Q8 scale-factor table used by the optional scaling LUT.
package ipgu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ipgu_state_t;

  localparam int DEF_WIN    = 20;
  localparam int DEF_STRIDE = 10;

  // Q8 fixed-point factors, 256 == 1.0, each step roughly 0.8x the previous
  localparam int SCALE_Q8 [8] = '{256, 205, 164, 131, 105, 84, 67, 54};

  function automatic logic [8:0] scale_q8(input logic [2:0] sel);
    return 9'(SCALE_Q8[sel]);
  endfunction

endpackage

// File: rtl/ipgu_window_addr_gen_if.sv
// ipgu_window_addr_gen_if: valid/ready pixel-address stream from the window
// address generator to the downstream buffer writer, including per-beat
// window and frame markers.
interface ipgu_window_addr_gen_if #(
  parameter int ADDR_W  = 9,
  parameter int SCALE_W = 8
);

  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  addr_x;
  logic [ADDR_W-1:0]  addr_y;
  logic [SCALE_W-1:0] scaled_x;
  logic [SCALE_W-1:0] scaled_y;
  logic               win_last;
  logic               frame_last;

  modport master (
    output out_valid, addr_x, addr_y, scaled_x, scaled_y, win_last, frame_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, addr_x, addr_y, scaled_x, scaled_y, win_last, frame_last,
    output out_ready
  );

endinterface

// File: rtl/ipgu_window_addr_gen_scale_lut.sv
// ipgu_scale_lut: combinational coordinate scaler. It multiplies a source
// address by the Q8 factor selected by sel, drops the 8 fraction bits and
// truncates the result to SCALE_W bits.
module ipgu_scale_lut
  import ipgu_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int SCALE_W = 8
) (
  input  logic [2:0]         sel,
  input  logic [ADDR_W-1:0]  addr,
  output logic [SCALE_W-1:0] scaled
);

  localparam int PROD_W = ADDR_W + 9;

  assign scaled = SCALE_W'((PROD_W'(addr) * PROD_W'(scale_q8(sel))) >> 8);

endmodule

// File: rtl/ipgu_window_addr_gen.sv
// ipgu_window_addr_gen: sliding-window pixel address generator for the IPGU.
// It walks a num_win_x by num_win_y grid of WIN x WIN windows spaced STRIDE
// apart, in raster order. Within each window it walks the pixels in raster
// order, and it emits one address beat per pixel through a single output
// register slice with valid/ready backpressure.
// Optional feature macro IPGU_ADDR_SCALE_EN: when defined, scaled_x and
// scaled_y come from the Q8 scale LUT; when undefined they are tied to 0.
module ipgu_window_addr_gen
  import ipgu_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int WIN     = DEF_WIN,
  parameter int STRIDE  = DEF_STRIDE,
  parameter int NWIN_W  = 4,
  parameter int SCALE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NWIN_W-1:0] num_win_x,
  input  logic [NWIN_W-1:0] num_win_y,
  input  logic [2:0]        scale_sel,
  output logic              busy,
  output logic              cfg_err,
  output logic              frame_done,
  ipgu_window_addr_gen_if.master out_if
);

  localparam int PX_W = (WIN > 1) ? $clog2(WIN) : 1;

  ipgu_state_t state, state_nxt;

  logic [PX_W-1:0]   px, py;
  logic [NWIN_W-1:0] wx, wy;
  logic [NWIN_W-1:0] nwx_q, nwy_q;
  logic [2:0]        sel_q;

  logic load, gen_beat, start_ok, start_bad, drain_hs;
  logic px_end, py_end, wx_end, wy_end;
  logic win_last_nxt, frame_last_nxt;
  logic [ADDR_W-1:0]  ax_nxt, ay_nxt;
  logic [SCALE_W-1:0] sx_nxt, sy_nxt;

  // State register; reset aborts any frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: RUN ends once the frame_last beat is loaded, and DRAIN
  // ends once that beat is accepted downstream
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (gen_beat && frame_last_nxt) state_nxt = DRAIN;
      DRAIN:   if (drain_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs and handshake qualifiers; start is only looked at in IDLE
  always_comb begin
    busy      = (state != IDLE);
    load      = !out_if.out_valid || out_if.out_ready;
    gen_beat  = (state == RUN) && load;
    start_ok  = (state == IDLE) && start && (num_win_x != '0) && (num_win_y != '0);
    start_bad = (state == IDLE) && start && ((num_win_x == '0) || (num_win_y == '0));
    drain_hs  = (state == DRAIN) && out_if.out_valid && out_if.out_ready;
  end

  // Latch the frame configuration so the inputs may change mid-frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nwx_q <= '0;
      nwy_q <= '0;
      sel_q <= '0;
    end else if (start_ok) begin
      nwx_q <= num_win_x;
      nwy_q <= num_win_y;
      sel_q <= scale_sel;
    end
  end

  // Current beat position, end-of-range flags and address/marker values
  always_comb begin
    px_end         = (px == PX_W'(WIN - 1));
    py_end         = (py == PX_W'(WIN - 1));
    wx_end         = (wx == nwx_q - NWIN_W'(1));
    wy_end         = (wy == nwy_q - NWIN_W'(1));
    win_last_nxt   = px_end && py_end;
    frame_last_nxt = win_last_nxt && wx_end && wy_end;
    ax_nxt         = ADDR_W'(wx) * ADDR_W'(STRIDE) + ADDR_W'(px);
    ay_nxt         = ADDR_W'(wy) * ADDR_W'(STRIDE) + ADDR_W'(py);
  end

  // Pixel/window counters step only when a beat enters the output slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px <= '0;
      py <= '0;
      wx <= '0;
      wy <= '0;
    end else if (start_ok) begin
      px <= '0;
      py <= '0;
      wx <= '0;
      wy <= '0;
    end else if (gen_beat) begin
      if (!px_end) begin
        px <= px + 1'b1;
      end else begin
        px <= '0;
        if (!py_end) begin
          py <= py + 1'b1;
        end else begin
          py <= '0;
          if (!wx_end) begin
            wx <= wx + 1'b1;
          end else begin
            wx <= '0;
            wy <= wy_end ? '0 : wy + 1'b1;
          end
        end
      end
    end
  end

`ifdef IPGU_ADDR_SCALE_EN
  ipgu_scale_lut #(.ADDR_W(ADDR_W), .SCALE_W(SCALE_W)) u_scale_x (
    .sel    (sel_q),
    .addr   (ax_nxt),
    .scaled (sx_nxt)
  );

  ipgu_scale_lut #(.ADDR_W(ADDR_W), .SCALE_W(SCALE_W)) u_scale_y (
    .sel    (sel_q),
    .addr   (ay_nxt),
    .scaled (sy_nxt)
  );
`else
  logic unused_sel;
  assign unused_sel = ^sel_q;
  assign sx_nxt     = '0;
  assign sy_nxt     = '0;
`endif

  // Output register slice: it reloads when empty or accepted, and holds
  // everything stable under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_if.out_valid  <= 1'b0;
      out_if.addr_x     <= '0;
      out_if.addr_y     <= '0;
      out_if.scaled_x   <= '0;
      out_if.scaled_y   <= '0;
      out_if.win_last   <= 1'b0;
      out_if.frame_last <= 1'b0;
    end else if (load) begin
      out_if.out_valid <= gen_beat;
      if (gen_beat) begin
        out_if.addr_x     <= ax_nxt;
        out_if.addr_y     <= ay_nxt;
        out_if.scaled_x   <= sx_nxt;
        out_if.scaled_y   <= sy_nxt;
        out_if.win_last   <= win_last_nxt;
        out_if.frame_last <= frame_last_nxt;
      end
    end
  end

  // Status pulses: frame_done follows the frame_last handshake, and cfg_err
  // follows a rejected start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= drain_hs;
      cfg_err    <= start_bad;
    end
  end

endmodule
